// File: rtl/timekeeper_1224.sv
// Time-of-day counter with 1 Hz prescaler, validated time load and
// registered 12/24 h display outputs for the 7-segment path.
module timekeeper_1224 #(
    parameter int TICK_DIV = 50000000,
    parameter int W        = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         mode,
    input  logic         set_valid,
    output logic         set_ready,
    input  logic [W-1:0] set_hour,
    input  logic [W-1:0] set_min,
    input  logic [W-1:0] set_sec,
    output logic         set_err,
    output logic [W-1:0] hour24,
    output logic [W-1:0] min_out,
    output logic [W-1:0] sec_out,
    output logic [W-1:0] hour_disp,
    output logic         pm,
    output logic         sec_pulse,
    output logic         day_pulse
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

    localparam logic [W-1:0] HOUR_MAX = W'(23);
    localparam logic [W-1:0] MS_MAX   = W'(59);
    localparam logic [W-1:0] NOON     = W'(12);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  hour_q, hour_d;
    logic [W-1:0]  min_q, min_d;
    logic [W-1:0]  sec_q, sec_d;
    logic [W-1:0]  hour_disp_q, hour_disp_d;
    logic          pm_q, pm_d;
    logic          set_ready_q, set_ready_d;
    logic          set_err_q, set_err_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          day_pulse_q, day_pulse_d;

    logic accept;
    logic in_range;
    logic presc_tc;
    logic tick;

    always_comb begin
        accept   = set_valid && set_ready_q;
        in_range = (set_hour <= HOUR_MAX) && (set_min <= MS_MAX)
                && (set_sec <= MS_MAX);
        presc_tc = (presc_q == PRESC_TC);
        // An accepted request (good or bad) swallows a coincident tick.
        tick     = run && presc_tc && !accept;

        state_d     = state_q;
        presc_d     = presc_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        set_ready_d = 1'b1;
        set_err_d   = 1'b0;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;

        if (accept) begin
            state_d     = ST_LOAD;
            set_ready_d = 1'b0;
            if (in_range) begin
                hour_d  = set_hour;
                min_d   = set_min;
                sec_d   = set_sec;
                presc_d = '0;
            end else begin
                set_err_d = 1'b1;
            end
        end else begin
            state_d = run ? ST_RUN : ST_STOP;
            if (run) begin
                presc_d = presc_tc ? '0 : presc_q + 1'b1;
            end
        end

        if (tick) begin
            sec_pulse_d = 1'b1;
            if (sec_q == MS_MAX) begin
                sec_d = '0;
                if (min_q == MS_MAX) begin
                    min_d = '0;
                    if (hour_q == HOUR_MAX) begin
                        hour_d      = '0;
                        day_pulse_d = 1'b1;
                    end else begin
                        hour_d = hour_q + 1'b1;
                    end
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        // Display follows the registered hour, so it lags one cycle.
        pm_d = (hour_q >= NOON);
        if (!mode) begin
            hour_disp_d = hour_q;
        end else if (hour_q == '0) begin
            hour_disp_d = NOON;
        end else if (hour_q > NOON) begin
            hour_disp_d = hour_q - NOON;
        end else begin
            hour_disp_d = hour_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOP;
            presc_q     <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            hour_disp_q <= NOON;
            pm_q        <= 1'b0;
            set_ready_q <= 1'b1;
            set_err_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            hour_disp_q <= hour_disp_d;
            pm_q        <= pm_d;
            set_ready_q <= set_ready_d;
            set_err_q   <= set_err_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign set_ready = set_ready_q;
    assign set_err   = set_err_q;
    assign hour24    = hour_q;
    assign min_out   = min_q;
    assign sec_out   = sec_q;
    assign hour_disp = hour_disp_q;
    assign pm        = pm_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;

endmodule

// File: doc/timekeeper_1224.md
Name: timekeeper_1224

Overview:
- Parametrised time-of-day counter for the digital-clock datapath: a prescaler derives a 1 Hz tick from the system clock; hours/minutes/seconds are kept in 24 h form.
- Drives the display path with a registered 12/24 h hour, AM/PM flag and day-rollover pulse.
- Supports a validated load handshake for time setting.
- Sits between the button/set logic and the 7-segment display driver.

Parameters:
- TICK_DIV, 50000000, clk cycles per second tick; legal range 2 or more.
- W, 7, width of the hour/min/sec value buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = timekeeping enabled; 0 = frozen, prescaler held.
- mode  in  1  1 = 12 h display, 0 = 24 h display.
- set_valid  in  1  load request; accepted when set_ready=1.
- set_ready  out  1  block can accept a load.
- set_hour  in  W  hour to load, 24 h form, 0..23.
- set_min  in  W  minute to load, 0..59.
- set_sec  in  W  second to load, 0..59.
- set_err  out  1  1-cycle pulse: request accepted but rejected as out of range.
- hour24  out  W  current hour, 0..23.
- min_out  out  W  current minute.
- sec_out  out  W  current second.
- hour_disp  out  W  hour as displayed per mode.
- pm  out  1  1 when hour24 >= 12, independent of mode.
- sec_pulse  out  1  1-cycle pulse on each applied second tick.
- day_pulse  out  1  1-cycle pulse on the 23:59:59 -> 00:00:00 step.

Behaviour:
- Reset values: hour24=0, min_out=0, sec_out=0, hour_disp=12, pm=0, set_ready=1, set_err=0, sec_pulse=0, day_pulse=0, prescaler=0, state=STOP.
- hour_disp at reset is 12 because the reset-time mode is treated as 12 h.
- States:
  - STOP: run=0. Prescaler is held, not cleared.
  - RUN: run=1.
  - LOAD: one cycle; set_ready=0.
- Transitions:
  - STOP <-> RUN follows run on the next edge.
  - set_valid with set_ready=1 -> LOAD from either STOP or RUN.
  - LOAD -> RUN if run=1, else STOP.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1 and wraps to 0.
  - At the terminal count, the cycle after sees sec_pulse=1 and the time is incremented.
- Increment:
  - sec 59 -> 0 with min+1.
  - min 59 -> 0 with hour+1.
  - hour 23 -> 0 with day_pulse=1, asserted in the same cycle as that sec_pulse.
- Load acceptance (cycle of set_valid and set_ready):
  - Range check: set_hour<=23, set_min<=59, set_sec<=59.
  - Pass: values are written at the LOAD edge and the prescaler is cleared to 0.
  - Fail: time is unchanged, prescaler is untouched, and set_err pulses 1 cycle (in LOAD).
  - set_valid while set_ready=0 is ignored and not queued.
- Simultaneous load and tick:
  - The load wins; that tick is dropped.
  - No sec_pulse or day_pulse is emitted for the dropped tick.
- Display conversion, registered with 1 cycle latency from hour24 or mode change:
  - mode=1: hour24=0 -> 12; 1..12 -> same; 13..23 -> hour24-12.
  - mode=0: hour_disp = hour24.
  - pm = (hour24 >= 12), registered alongside hour_disp.
- Arithmetic: all compares and subtracts are unsigned at width W; no value exceeds its range after reset.
- run toggling mid-second: the prescaler resumes from its held count, so no partial-second loss.
- Reset is asynchronous at any point, including mid-LOAD: all outputs return to reset values immediately, and any pending load is discarded.

Test Plan (TICK_DIV=4):
- Reset, then run=1 for 12 cycles -> sec_pulse on cycles 4, 8, 12 (one pulse every 4 cycles); sec_out goes 0 -> 1 -> 2 -> 3; hour_disp=12, pm=0.
- Load 23:59:58 with run=1, then 8 cycles -> sec_out 59, then 00:00:00 with day_pulse=1 coincident with that sec_pulse; pm goes 1 -> 0; hour_disp goes 11 -> 12 in mode=1.
- Sweep hour24 0, 1, 12, 13, 23 via load with mode=1 -> hour_disp 12, 1, 12, 1, 11 and pm 0, 0, 1, 1, 1; with mode=0 -> hour_disp equals hour24, updated one cycle after the change.
- Load 24:00:00 and then 10:60:00 -> set_err pulses once for each request; time and prescaler are unchanged; set_ready=0 for exactly 1 cycle each.
- Assert set_valid on the prescaler terminal-count cycle with 05:06:07 -> time becomes 05:06:07; no sec_pulse is emitted; the next sec_pulse arrives 4 cycles after LOAD.
- run=0 at prescaler count 2 for 10 cycles, then run=1 -> next sec_pulse 2 cycles later. Separately, assert rst during LOAD -> all outputs at reset values on the next sample.
